// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit: repair-action bit positions,
// checkpoint layout, FSM encodings and a saturating counter helper.
package branch_redirect_unit_pkg;

    localparam int REPAIR_ACTION_W = 4;
    localparam int RA_NEED_REPAIR  = 0;
    localparam int RA_CALL         = 1;
    localparam int RA_RET          = 2;
    localparam int RA_COND         = 3;

    localparam int DEF_GHR_W      = 8;
    localparam int DEF_RAS_PTR_W  = 3;
    localparam int DEF_UPD_DEPTH  = 4;

    // Checkpoint is {rasPtr, ghr}: ghr starts at bit 0, rasPtr sits directly above it.
    localparam int CKPT_GHR_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PEND_BR  = 2'd1,
        ST_PEND_EXC = 2'd2
    } bru_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bru_upd_fifo.sv
// Training-update FIFO: synchronous storage, async active-low reset, and a
// combinational drop flag for pushes that arrive while full with no pop.
module bru_upd_fifo
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 65
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq_ready,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic              drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;
    logic              deq_s;
    logic              push_s;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign head_valid = (count_r != {CNT_W{1'b0}});
    assign deq_s      = head_valid && deq_ready;
    assign push_s     = enq && (!full_s || deq_s);
    assign drop       = enq && full_s && !deq_s;
    assign head_data  = head_valid ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are qualified by head_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= enq_data;
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Front-end redirect/restore/training hub fed by branch amend and CP0 flush.
// Define BRU_PERF_CNT_EN to build the saturating performance counters.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int GHR_W     = DEF_GHR_W,
    parameter int RAS_PTR_W = DEF_RAS_PTR_W,
    parameter int UPD_DEPTH = DEF_UPD_DEPTH
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         CP0_excOccur_w_i,
    input  logic [31:0]                  CP0_excDest_w_i,
    input  logic                         SBA_flush_w_i,
    input  logic [31:0]                  SBA_erroVAddr_w_i,
    input  logic [31:0]                  SBA_corrDest_w_i,
    input  logic                         SBA_corrTake_w_i,
    input  logic [GHR_W+RAS_PTR_W-1:0]   SBA_checkPoint_w_i,
    input  logic [REPAIR_ACTION_W-1:0]   SBA_repairAction_w_i,
    input  logic                         FET_redirectReady_w_i,
    output logic                         BRU_redirectValid_w_o,
    output logic [31:0]                  BRU_redirectPC_w_o,
    output logic                         BRU_frontFlush_w_o,
    output logic                         BRU_restoreValid_w_o,
    output logic [GHR_W-1:0]             BRU_restoreGhr_w_o,
    output logic [RAS_PTR_W-1:0]         BRU_restoreRasPtr_w_o,
    output logic                         BRU_updValid_w_o,
    input  logic                         PRD_updReady_w_i,
    output logic [31:0]                  BRU_updPC_w_o,
    output logic [31:0]                  BRU_updDest_w_o,
    output logic                         BRU_updTake_w_o,
    output logic                         BRU_updDrop_w_o,
    output logic [31:0]                  BRU_cntSba_o,
    output logic [31:0]                  BRU_cntExc_o,
    output logic [31:0]                  BRU_cntDrop_o
);

    localparam int CKPT_PTR_LSB = CKPT_GHR_LSB + GHR_W;
    localparam int UPD_W        = 65;

    bru_state_e             state_r;
    logic                   redirect_valid_r;
    logic [31:0]            redirect_pc_r;
    logic                   front_flush_r;
    logic                   restore_valid_r;
    logic [GHR_W-1:0]       restore_ghr_r;
    logic [RAS_PTR_W-1:0]   restore_ptr_r;

    logic                   sba_evt_s;
    logic                   exc_evt_s;
    logic                   sba_capture_s;
    logic [GHR_W-1:0]       ckpt_ghr_s;
    logic [RAS_PTR_W-1:0]   ckpt_ptr_s;
    logic [GHR_W-1:0]       next_ghr_s;
    logic [RAS_PTR_W-1:0]   next_ptr_s;
    logic [31:0]            br_target_s;
    logic [UPD_W-1:0]       upd_head_s;
    logic                   upd_drop_s;

    assign sba_evt_s     = SBA_flush_w_i && SBA_repairAction_w_i[RA_NEED_REPAIR];
    assign exc_evt_s     = CP0_excOccur_w_i;
    // A pending exception redirect shadows any branch correction until accepted.
    assign sba_capture_s = sba_evt_s && !exc_evt_s && (state_r != ST_PEND_EXC);
    assign ckpt_ghr_s    = SBA_checkPoint_w_i[CKPT_GHR_LSB +: GHR_W];
    assign ckpt_ptr_s    = SBA_checkPoint_w_i[CKPT_PTR_LSB +: RAS_PTR_W];

    // Repaired history/pointer and corrected fetch target for a branch capture.
    always_comb begin
        next_ghr_s  = ckpt_ghr_s;
        next_ptr_s  = ckpt_ptr_s;
        br_target_s = SBA_erroVAddr_w_i + 32'd8;
        if (SBA_repairAction_w_i[RA_COND]) begin
            next_ghr_s = {ckpt_ghr_s[GHR_W-2:0], SBA_corrTake_w_i};
        end else begin
            next_ghr_s = ckpt_ghr_s;
        end
        if (SBA_repairAction_w_i[RA_CALL]) begin
            next_ptr_s = ckpt_ptr_s + RAS_PTR_W'(1);
        end else if (SBA_repairAction_w_i[RA_RET]) begin
            next_ptr_s = ckpt_ptr_s - RAS_PTR_W'(1);
        end else begin
            next_ptr_s = ckpt_ptr_s;
        end
        if (SBA_corrTake_w_i) begin
            br_target_s = SBA_corrDest_w_i;
        end else begin
            br_target_s = SBA_erroVAddr_w_i + 32'd8;
        end
    end

    // Redirect FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
            front_flush_r    <= 1'b0;
            restore_valid_r  <= 1'b0;
            restore_ghr_r    <= {GHR_W{1'b0}};
            restore_ptr_r    <= {RAS_PTR_W{1'b0}};
        end else begin
            front_flush_r   <= 1'b0;
            restore_valid_r <= 1'b0;
            if (exc_evt_s) begin
                state_r          <= ST_PEND_EXC;
                redirect_valid_r <= 1'b1;
                redirect_pc_r    <= CP0_excDest_w_i;
                front_flush_r    <= 1'b1;
            end else if (sba_capture_s) begin
                state_r          <= ST_PEND_BR;
                redirect_valid_r <= 1'b1;
                redirect_pc_r    <= br_target_s;
                front_flush_r    <= 1'b1;
                restore_valid_r  <= 1'b1;
                restore_ghr_r    <= next_ghr_s;
                restore_ptr_r    <= next_ptr_s;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_PEND_BR, ST_PEND_EXC: begin
                        if (FET_redirectReady_w_i) begin
                            state_r          <= ST_IDLE;
                            redirect_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r          <= ST_IDLE;
                        redirect_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    bru_upd_fifo #(
        .DEPTH  (UPD_DEPTH),
        .DATA_W (UPD_W)
    ) u_upd_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .enq        (sba_evt_s),
        .enq_data   ({SBA_erroVAddr_w_i, SBA_corrDest_w_i, SBA_corrTake_w_i}),
        .deq_ready  (PRD_updReady_w_i),
        .head_valid (BRU_updValid_w_o),
        .head_data  (upd_head_s),
        .drop       (upd_drop_s)
    );

    assign BRU_updPC_w_o         = upd_head_s[64:33];
    assign BRU_updDest_w_o       = upd_head_s[32:1];
    assign BRU_updTake_w_o       = upd_head_s[0];
    assign BRU_updDrop_w_o       = upd_drop_s;
    assign BRU_redirectValid_w_o = redirect_valid_r;
    assign BRU_redirectPC_w_o    = redirect_pc_r;
    assign BRU_frontFlush_w_o    = front_flush_r;
    assign BRU_restoreValid_w_o  = restore_valid_r;
    assign BRU_restoreGhr_w_o    = restore_ghr_r;
    assign BRU_restoreRasPtr_w_o = restore_ptr_r;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] cnt_sba_r;
    logic [31:0] cnt_exc_r;
    logic [31:0] cnt_drop_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_sba_r  <= 32'd0;
            cnt_exc_r  <= 32'd0;
            cnt_drop_r <= 32'd0;
        end else begin
            if (sba_capture_s) begin
                cnt_sba_r <= sat_inc32(cnt_sba_r);
            end
            if (exc_evt_s) begin
                cnt_exc_r <= sat_inc32(cnt_exc_r);
            end
            if (upd_drop_s) begin
                cnt_drop_r <= sat_inc32(cnt_drop_r);
            end
        end
    end

    assign BRU_cntSba_o  = cnt_sba_r;
    assign BRU_cntExc_o  = cnt_exc_r;
    assign BRU_cntDrop_o = cnt_drop_r;
`else
    assign BRU_cntSba_o  = 32'd0;
    assign BRU_cntExc_o  = 32'd0;
    assign BRU_cntDrop_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_branch_redirect_unit;

    localparam int GHR_W     = 8;
    localparam int RAS_PTR_W = 3;
    localparam int UPD_DEPTH = 4;
    localparam int CK_W      = GHR_W + RAS_PTR_W;
`ifdef BRU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk, rst;
    logic exc_occur;  logic [31:0] exc_dest;
    logic sba_flush;  logic [31:0] sba_err, sba_dest;
    logic sba_take;   logic [CK_W-1:0] sba_ckpt; logic [3:0] sba_ra;
    logic fet_ready,  prd_ready;
    logic redir_valid; logic [31:0] redir_pc;
    logic front_flush, restore_valid;
    logic [GHR_W-1:0] restore_ghr; logic [RAS_PTR_W-1:0] restore_ptr;
    logic upd_valid;  logic [31:0] upd_pc, upd_dest;
    logic upd_take, upd_drop;
    logic [31:0] cnt_sba, cnt_exc, cnt_drop;

    branch_redirect_unit #(.GHR_W(GHR_W), .RAS_PTR_W(RAS_PTR_W), .UPD_DEPTH(UPD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .CP0_excOccur_w_i(exc_occur), .CP0_excDest_w_i(exc_dest),
        .SBA_flush_w_i(sba_flush), .SBA_erroVAddr_w_i(sba_err),
        .SBA_corrDest_w_i(sba_dest), .SBA_corrTake_w_i(sba_take),
        .SBA_checkPoint_w_i(sba_ckpt), .SBA_repairAction_w_i(sba_ra),
        .FET_redirectReady_w_i(fet_ready),
        .BRU_redirectValid_w_o(redir_valid), .BRU_redirectPC_w_o(redir_pc),
        .BRU_frontFlush_w_o(front_flush), .BRU_restoreValid_w_o(restore_valid),
        .BRU_restoreGhr_w_o(restore_ghr), .BRU_restoreRasPtr_w_o(restore_ptr),
        .BRU_updValid_w_o(upd_valid), .PRD_updReady_w_i(prd_ready),
        .BRU_updPC_w_o(upd_pc), .BRU_updDest_w_o(upd_dest),
        .BRU_updTake_w_o(upd_take), .BRU_updDrop_w_o(upd_drop),
        .BRU_cntSba_o(cnt_sba), .BRU_cntExc_o(cnt_exc), .BRU_cntDrop_o(cnt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the front end should currently see.
    bit          m_valid, m_exc, m_flush, m_rvalid;
    logic [31:0] m_pc;
    int          m_ghr, m_ptr;
    logic [64:0] m_q[$];
    logic [31:0] m_cnt_sba, m_cnt_exc, m_cnt_drop;

    int   n_vec  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic last_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_exc = 0; m_flush = 0; m_rvalid = 0;
        m_pc = 32'd0; m_ghr = 0; m_ptr = 0;
        m_q.delete();
        m_cnt_sba = 32'd0; m_cnt_exc = 32'd0; m_cnt_drop = 32'd0;
    endtask

    task automatic compare_all();
        logic [64:0] head;
        chk("redirect_valid", redir_valid, m_valid);
        if (m_valid) chk("redirect_pc", redir_pc, m_pc);
        chk("front_flush", front_flush, m_flush);
        chk("restore_valid", restore_valid, m_rvalid);
        if (m_rvalid) begin
            chk("restore_ghr", restore_ghr, m_ghr);
            chk("restore_ras_ptr", restore_ptr, m_ptr);
        end
        chk("upd_valid", upd_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("upd_pc", upd_pc, head[64:33]);
            chk("upd_dest", upd_dest, head[32:1]);
            chk("upd_take", upd_take, head[0]);
        end
        chk("cnt_sba", cnt_sba, PERF ? m_cnt_sba : 32'd0);
        chk("cnt_exc", cnt_exc, PERF ? m_cnt_exc : 32'd0);
        chk("cnt_drop", cnt_drop, PERF ? m_cnt_drop : 32'd0);
    endtask

    // Apply one cycle of inputs (called at a negedge), advance model, check after edge.
    task automatic drive(input logic exc, input logic [31:0] edst, input logic sba,
                         input logic [31:0] err, input logic [31:0] dst, input logic take,
                         input logic [CK_W-1:0] ckpt, input logic [3:0] ra,
                         input logic fr, input logic ur);
        bit evt_sba, do_deq, exp_drop;
        exc_occur = exc; exc_dest = edst; sba_flush = sba; sba_err = err;
        sba_dest = dst; sba_take = take; sba_ckpt = ckpt; sba_ra = ra;
        fet_ready = fr; prd_ready = ur;
        #1;
        evt_sba  = sba && ra[0];
        do_deq   = (m_q.size() > 0) && ur;
        exp_drop = evt_sba && (m_q.size() == UPD_DEPTH) && !do_deq;
        last_drop = upd_drop;
        chk("upd_drop", upd_drop, exp_drop);
        if (do_deq) void'(m_q.pop_front());
        if (evt_sba && !exp_drop) m_q.push_back({err, dst, take});
        if (exp_drop) m_cnt_drop = sat(m_cnt_drop);
        m_flush = 0; m_rvalid = 0;
        if (exc) begin
            m_valid = 1; m_exc = 1; m_pc = edst; m_flush = 1;
            m_cnt_exc = sat(m_cnt_exc);
        end else if (evt_sba && !(m_valid && m_exc)) begin
            m_valid = 1; m_exc = 0; m_flush = 1; m_rvalid = 1;
            m_pc = take ? dst : err + 32'd8;
            m_ghr = ra[3] ? ((int'(ckpt[GHR_W-1:0]) * 2) + int'(take)) % 256 : int'(ckpt[GHR_W-1:0]);
            m_ptr = int'(ckpt[CK_W-1:GHR_W]);
            if (ra[1]) m_ptr = (m_ptr + 1) % 8;
            else if (ra[2]) m_ptr = (m_ptr + 7) % 8;
            m_cnt_sba = sat(m_cnt_sba);
        end else if (m_valid && fr) begin
            m_valid = 0;
        end
        @(negedge clk);
        n_vec++;
        compare_all();
    endtask

    task automatic idle(input logic fr, input logic ur);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, {CK_W{1'b0}}, 4'd0, fr, ur);
    endtask

    task automatic sba_ev(input logic [31:0] err, input logic [31:0] dst, input logic fr, input logic ur);
        drive(1'b0, 32'd0, 1'b1, err, dst, 1'b1, {CK_W{1'b0}}, 4'b1001, fr, ur);
    endtask

    // Asynchronous reset assertion between clock edges, then release on a negedge.
    task automatic do_reset();
        rst = 1'b0;
        exc_occur = 0; exc_dest = 0; sba_flush = 0; sba_err = 0; sba_dest = 0;
        sba_take = 0; sba_ckpt = 0; sba_ra = 0; fet_ready = 0; prd_ready = 0;
        #1;
        chk("rst_redirect_valid", redir_valid, 1'b0);
        chk("rst_redirect_pc", redir_pc, 32'd0);
        chk("rst_front_flush", front_flush, 1'b0);
        chk("rst_restore_valid", restore_valid, 1'b0);
        chk("rst_restore_ghr", restore_ghr, 8'd0);
        chk("rst_restore_ptr", restore_ptr, 3'd0);
        chk("rst_upd_valid", upd_valid, 1'b0);
        chk("rst_upd_drop", upd_drop, 1'b0);
        chk("rst_cnt_sba", cnt_sba, 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // Taken conditional branch with checkpoint ghr=0x5A, ptr=3.
        drive(1'b0, 32'd0, 1'b1, 32'h1000, 32'h2000, 1'b1, {3'd3, 8'h5A}, 4'b1001, 1'b0, 1'b0);
        chk("t1_pc", redir_pc, 32'h2000);
        chk("t1_flush", front_flush, 1'b1);
        chk("t1_restore", restore_valid, 1'b1);
        chk("t1_ghr", restore_ghr, 8'hB5);
        chk("t1_ptr", restore_ptr, 3'd3);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0);
            chk("t1_hold_valid", redir_valid, 1'b1);
            chk("t1_hold_pc", redir_pc, 32'h2000);
            chk("t1_hold_flush", front_flush, 1'b0);
        end
        idle(1'b1, 1'b1);
        chk("t1_accept", redir_valid, 1'b0);

        // Not-taken return with pointer wrap 0 -> 7.
        drive(1'b0, 32'd0, 1'b1, 32'h1000, 32'h4444, 1'b0, {3'd0, 8'h00}, 4'b0101, 1'b0, 1'b0);
        chk("t2_pc", redir_pc, 32'h1008);
        chk("t2_ptr", restore_ptr, 3'd7);
        chk("t2_upd_pc", upd_pc, 32'h1000);
        chk("t2_upd_dest", upd_dest, 32'h4444);
        chk("t2_upd_take", upd_take, 1'b0);
        idle(1'b1, 1'b1);

        // Exception and branch in the same cycle, then branch while exception pending.
        drive(1'b1, 32'hBFC0_0380, 1'b1, 32'h5000, 32'h6000, 1'b1, {CK_W{1'b0}}, 4'b1001, 1'b0, 1'b0);
        chk("t3_pc", redir_pc, 32'hBFC0_0380);
        chk("t3_no_restore", restore_valid, 1'b0);
        chk("t3_flush", front_flush, 1'b1);
        chk("t3_upd_valid", upd_valid, 1'b1);
        chk("t3_upd_pc", upd_pc, 32'h5000);
        sba_ev(32'h5100, 32'h7000, 1'b0, 1'b0);
        chk("t3_ignored_pc", redir_pc, 32'hBFC0_0380);
        chk("t3_ignored_flush", front_flush, 1'b0);
        chk("t3_ignored_restore", restore_valid, 1'b0);
        idle(1'b1, 1'b1);
        chk("t3_accept", redir_valid, 1'b0);
        idle(1'b0, 1'b1);
        chk("t3_drained", upd_valid, 1'b0);

        // New branch arriving in the accept cycle reloads the redirect.
        sba_ev(32'h1000, 32'h2000, 1'b0, 1'b0);
        sba_ev(32'h1100, 32'h3000, 1'b1, 1'b0);
        chk("t4_valid", redir_valid, 1'b1);
        chk("t4_pc", redir_pc, 32'h3000);
        chk("t4_flush", front_flush, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);

        // Reset in the middle of a pending branch with two queued updates.
        sba_ev(32'h0A00, 32'h0B00, 1'b0, 1'b0);
        sba_ev(32'h0A10, 32'h0B10, 1'b0, 1'b0);
        chk("t6_pre_valid", redir_valid, 1'b1);
        do_reset();
        idle(1'b0, 1'b0);
        chk("t6_post_upd_valid", upd_valid, 1'b0);
        chk("t6_post_redirect", redir_valid, 1'b0);

        // Five updates into a four-entry FIFO with the predictor stalled.
        for (int i = 0; i < 5; i++) begin
            sba_ev(32'h100 * (i + 1), 32'h8000 + 32'(i), 1'b0, 1'b0);
        end
        chk("t5_drop", last_drop, 1'b1);
        chk("t5_cnt_drop", cnt_drop, PERF ? 32'd1 : 32'd0);
        chk("t5_cnt_sba", cnt_sba, PERF ? 32'd5 : 32'd0);
        chk("t5_head_pc", upd_pc, 32'h100);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) == 0,
                  $urandom, $urandom, 1'($urandom), CK_W'($urandom), 4'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
